// File: rtl/vga_timing_ctrl.sv
// VGA raster timing generator: waits for PLL lock plus enable, then produces registered
// sync/blank/coordinate outputs; a graceful stop finishes the current frame, while lock loss stops at once.
module vga_timing_ctrl #(
  parameter int H_VISIBLE  = 640,
  parameter int H_FRONT    = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BACK     = 48,
  parameter int V_VISIBLE  = 480,
  parameter int V_FRONT    = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BACK     = 33,
  parameter bit SYNC_POL   = 1'b0,
  parameter int LOCK_DELAY = 16
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        locked,
  input  logic        enable,
  output logic        HSYNC,
  output logic        VSYNC,
  output logic        video_active,
  output logic [10:0] pixel_x,
  output logic [10:0] pixel_y,
  output logic        line_start,
  output logic        frame_start,
  output logic        running
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int SW      = (LOCK_DELAY > 1) ? $clog2(LOCK_DELAY) : 1;

  localparam logic [10:0] H_LAST   = 11'(H_TOTAL - 1);
  localparam logic [10:0] V_LAST   = 11'(V_TOTAL - 1);
  localparam logic [10:0] H_VIS    = 11'(H_VISIBLE);
  localparam logic [10:0] V_VIS    = 11'(V_VISIBLE);
  localparam logic [10:0] HS_START = 11'(H_VISIBLE + H_FRONT);
  localparam logic [10:0] HS_END   = 11'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [10:0] VS_START = 11'(V_VISIBLE + V_FRONT);
  localparam logic [10:0] VS_END   = 11'(V_VISIBLE + V_FRONT + V_SYNC);
  localparam logic [SW-1:0] SETTLE_LAST = SW'(LOCK_DELAY - 1);

  typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_RUN, S_DRAIN} state_t;

  state_t        state, state_nxt;
  logic [SW-1:0] settle_cnt, settle_nxt;
  logic [10:0]   x_nxt, y_nxt, x_adv, y_adv;
  logic          qual, eol, eof, run_nxt;

  always_comb begin
    state_nxt  = state;
    settle_nxt = '0;
    x_nxt      = '0;
    y_nxt      = '0;
    qual       = locked && enable;
    eol        = (pixel_x == H_LAST);
    eof        = eol && (pixel_y == V_LAST);
    x_adv      = eol ? 11'd0 : pixel_x + 11'd1;
    y_adv      = eol ? (eof ? 11'd0 : pixel_y + 11'd1) : pixel_y;

    case (state)
      S_IDLE: begin
        if (qual) state_nxt = S_SETTLE;
      end
      S_SETTLE: begin
        if (!qual)
          state_nxt = S_IDLE;
        else if (settle_cnt == SETTLE_LAST)
          state_nxt = S_RUN;
        else
          settle_nxt = settle_cnt + 1'b1;
      end
      S_RUN, S_DRAIN: begin
        // Stopping on the last pixel of a frame never starts another one.
        if (!locked || (!enable && eof)) begin
          state_nxt = S_IDLE;
        end else begin
          x_nxt     = x_adv;
          y_nxt     = y_adv;
          state_nxt = enable ? S_RUN : S_DRAIN;
        end
      end
      default: state_nxt = S_IDLE;
    endcase

    run_nxt = (state_nxt == S_RUN) || (state_nxt == S_DRAIN);
  end

  // Outputs are decoded from the next coordinates so they register together.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state        <= S_IDLE;
      settle_cnt   <= '0;
      pixel_x      <= '0;
      pixel_y      <= '0;
      HSYNC        <= ~SYNC_POL;
      VSYNC        <= ~SYNC_POL;
      video_active <= 1'b0;
      line_start   <= 1'b0;
      frame_start  <= 1'b0;
      running      <= 1'b0;
    end else begin
      state        <= state_nxt;
      settle_cnt   <= settle_nxt;
      pixel_x      <= x_nxt;
      pixel_y      <= y_nxt;
      HSYNC        <= (run_nxt && x_nxt >= HS_START && x_nxt < HS_END) ? SYNC_POL : ~SYNC_POL;
      VSYNC        <= (run_nxt && y_nxt >= VS_START && y_nxt < VS_END) ? SYNC_POL : ~SYNC_POL;
      video_active <= run_nxt && (x_nxt < H_VIS) && (y_nxt < V_VIS);
      line_start   <= run_nxt && (x_nxt == 11'd0);
      frame_start  <= run_nxt && (x_nxt == 11'd0) && (y_nxt == 11'd0);
      running      <= run_nxt;
    end
  end

endmodule
